// File: rtl/tdm_demux_4b_pkg.sv
// Shared definitions for the TDM receive demux: FSM state encodings and a
// constant-evaluable ceil(log2) used to size the channel select.
package tdm_demux_4b_pkg;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  // Never returns less than 1, so a select port always has at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/tdm_demux_4b_ch_reg.sv
// One channel holding register: loads the shared data word when its enable is
// set, otherwise holds the last value; cleared asynchronously.
module demux_ch_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/tdm_demux_4b.sv
// Receive side of the time-multiplexed word bus: routes each valid word to a
// per-channel register by explicit select or by position within an SOF frame.
module tdm_demux_4b
  import tdm_demux_4b_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 2,
  localparam int CW       = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          din,
  input  logic                      din_valid,
  input  logic                      sof,
  input  logic                      auto_mode,
  input  logic [CW-1:0]             sel,
  input  logic                      err_clr,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic [CHANNELS-1:0]       ch_update,
  output logic                      frame_done,
  output logic                      frame_err,
  output logic                      busy
);

  logic [0:0]          r_state;
  logic [CW-1:0]       r_cnt;
  logic [CHANNELS-1:0] r_ch_update;
  logic                r_frame_done;
  logic                r_frame_err;

  logic [0:0]          w_nstate;
  logic [CW-1:0]       w_ncnt;
  logic [CW-1:0]       w_idx;
  logic                w_wr;
  logic                w_err;
  logic                w_done;
  logic                w_sel_ok;
  logic [CHANNELS-1:0] w_load;

  // Out-of-range selects are possible whenever CHANNELS is not a power of two.
  always_comb begin
    w_sel_ok = 1'b0;
    for (int k = 0; k < CHANNELS; k++)
      if (sel == CW'(k)) w_sel_ok = 1'b1;
  end

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_idx    = '0;
    w_wr     = 1'b0;
    w_err    = 1'b0;
    w_done   = 1'b0;
    if (!auto_mode) begin
      // Explicit mode pins the FSM to IDLE, which also aborts any open frame.
      w_nstate = ST_IDLE;
      w_ncnt   = '0;
      if (din_valid) begin
        w_idx = sel;
        w_wr  = w_sel_ok;
        w_err = !w_sel_ok;
      end
    end else if (din_valid) begin
      if (sof) begin
        w_wr     = 1'b1;
        w_idx    = '0;
        w_ncnt   = CW'(1);
        w_nstate = ST_COLLECT;
        w_err    = (r_state == ST_COLLECT);
      end else if (r_state == ST_IDLE) begin
        w_err = 1'b1;
      end else begin
        w_wr  = 1'b1;
        w_idx = r_cnt;
        if (r_cnt == CW'(CHANNELS-1)) begin
          w_done   = 1'b1;
          w_ncnt   = '0;
          w_nstate = ST_IDLE;
        end else begin
          w_ncnt = r_cnt + CW'(1);
        end
      end
    end
  end

  always_comb begin
    w_load = '0;
    for (int k = 0; k < CHANNELS; k++)
      w_load[k] = w_wr && (w_idx == CW'(k));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_ch_update  <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_nstate;
      r_cnt        <= w_ncnt;
      r_ch_update  <= w_load;
      r_frame_done <= w_done;
      // A new error in the same cycle as err_clr keeps the flag set.
      if (w_err)        r_frame_err <= 1'b1;
      else if (err_clr) r_frame_err <= 1'b0;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    demux_ch_reg #(.WIDTH(WIDTH)) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (w_load[g]),
      .d     (din),
      .q     (dout[g*WIDTH +: WIDTH])
    );
  end

  assign ch_update  = r_ch_update;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state == ST_COLLECT);

endmodule

// File: tb/tb_tdm_demux_4b.sv
// Directed bench for tdm_demux_4b: a 2-channel instance for the main sequences
// and a 3-channel instance for the out-of-range select case.
module tb_tdm_demux_4b;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        sof = 1'b0;
  logic        auto_mode = 1'b0;
  logic [0:0]  sel = '0;
  logic        err_clr = 1'b0;
  logic [7:0]  dout;
  logic [1:0]  ch_update;
  logic        frame_done, frame_err, busy;

  logic        din_valid3 = 1'b0;
  logic [1:0]  sel3 = '0;
  logic [11:0] dout3;
  logic [2:0]  ch_update3;
  logic        frame_done3, frame_err3, busy3;

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;

  always #5 clk = ~clk;

  tdm_demux_4b #(.WIDTH(4), .CHANNELS(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
    .auto_mode(auto_mode), .sel(sel), .err_clr(err_clr), .dout(dout),
    .ch_update(ch_update), .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
  );

  tdm_demux_4b #(.WIDTH(4), .CHANNELS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid3), .sof(1'b0),
    .auto_mode(1'b0), .sel(sel3), .err_clr(1'b0), .dout(dout3),
    .ch_update(ch_update3), .frame_done(frame_done3), .frame_err(frame_err3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Apply the current inputs across one rising edge, then sample just after it.
  task automatic step();
    @(posedge clk);
    #1;
    if (frame_done) n_done++;
  endtask

  task automatic drive(input logic v, input logic s, input logic [3:0] d);
    din_valid = v; sof = s; din = d;
  endtask

  initial begin
    #12;
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_upd", 32'(ch_update), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(frame_err), 32'h0);
    chk("rst_done", 32'(frame_done), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // 1: explicit mode writes by select
    auto_mode = 1'b0; sel = 1'b0; drive(1, 0, 4'h3); step();
    chk("t1_upd0", 32'(ch_update), 32'h1);
    chk("t1_dout0", 32'(dout), 32'h03);
    sel = 1'b1; drive(1, 0, 4'hC); step();
    chk("t1_upd1", 32'(ch_update), 32'h2);
    chk("t1_dout1", 32'(dout), 32'hC3);
    chk("t1_err", 32'(frame_err), 32'h0);
    drive(0, 0, 4'h0); step();
    chk("t1_upd_idle", 32'(ch_update), 32'h0);

    // 5: 3-channel build, valid write then an out-of-range select
    sel3 = 2'd2; din_valid3 = 1'b1; din = 4'hA; step();
    chk("t5_upd_ok", 32'(ch_update3), 32'h4);
    chk("t5_dout_ok", 32'(dout3), 32'hA00);
    sel3 = 2'd3; din = 4'hF; step();
    chk("t5_upd_bad", 32'(ch_update3), 32'h0);
    chk("t5_err", 32'(frame_err3), 32'h1);
    chk("t5_dout_bad", 32'(dout3), 32'hA00);
    din_valid3 = 1'b0; step();

    // 2: one auto frame
    n_done = 0;
    auto_mode = 1'b1; drive(1, 1, 4'h1); step();
    chk("t2_busy", 32'(busy), 32'h1);
    chk("t2_dout_a", 32'(dout), 32'hC1);
    chk("t2_done_a", 32'(frame_done), 32'h0);
    drive(1, 0, 4'h8); step();
    chk("t2_dout_b", 32'(dout), 32'h81);
    chk("t2_done_b", 32'(frame_done), 32'h1);
    chk("t2_busy_b", 32'(busy), 32'h0);
    drive(0, 0, 4'h0); step();
    chk("t2_done_c", 32'(frame_done), 32'h0);
    chk("t2_ndone", 32'(n_done), 32'd1);

    // 3: word without SOF while idle
    drive(1, 0, 4'h5); step();
    chk("t3_dout", 32'(dout), 32'h81);
    chk("t3_upd", 32'(ch_update), 32'h0);
    chk("t3_err", 32'(frame_err), 32'h1);
    // clear collides with a fresh error: error wins
    err_clr = 1'b1; step();
    chk("t3_clr_vs_err", 32'(frame_err), 32'h1);
    drive(0, 0, 4'h0); step();
    err_clr = 1'b0;
    chk("t3_clr", 32'(frame_err), 32'h0);

    // 4: early SOF restarts the frame
    n_done = 0;
    drive(1, 1, 4'h2); step();
    chk("t4_dout_a", 32'(dout), 32'h82);
    drive(1, 1, 4'h7); step();
    chk("t4_err", 32'(frame_err), 32'h1);
    chk("t4_busy", 32'(busy), 32'h1);
    chk("t4_dout_b", 32'(dout), 32'h87);
    drive(1, 0, 4'hE); step();
    chk("t4_dout_c", 32'(dout), 32'hE7);
    drive(0, 0, 4'h0); step();
    chk("t4_ndone", 32'(n_done), 32'd1);
    err_clr = 1'b1; step(); err_clr = 1'b0;

    // mode drop mid-frame aborts silently; same-cycle word goes by select
    drive(1, 1, 4'hB); step();
    chk("mc_busy_a", 32'(busy), 32'h1);
    auto_mode = 1'b0; sel = 1'b1; drive(1, 0, 4'hD); step();
    chk("mc_busy_b", 32'(busy), 32'h0);
    chk("mc_dout", 32'(dout), 32'hDB);
    chk("mc_err", 32'(frame_err), 32'h0);
    chk("mc_done", 32'(frame_done), 32'h0);
    drive(0, 0, 4'h0); step();

    // 6: asynchronous reset mid-frame
    auto_mode = 1'b1; drive(1, 1, 4'h4); step();
    chk("t6_busy_a", 32'(busy), 32'h1);
    chk("t6_dout_a", 32'(dout), 32'hD4);
    drive(0, 0, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_dout", 32'(dout), 32'h00);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_upd", 32'(ch_update), 32'h0);
    chk("t6_rst_err3", 32'(frame_err3), 32'h0);
    n_done = 0;
    step(); step();
    @(negedge clk); rst_n = 1'b1;
    drive(1, 1, 4'h9); step();
    chk("t6_dout_b", 32'(dout), 32'h09);
    drive(1, 0, 4'h6); step();
    chk("t6_dout_c", 32'(dout), 32'h69);
    chk("t6_done", 32'(frame_done), 32'h1);
    drive(0, 0, 4'h0); step();
    chk("t6_ndone", 32'(n_done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
